// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the block RAM arbiter: requester ownership and FSM states.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_L    = 2'd3
    } owner_e;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_CAPT  = 3'd3,
        ARB_DONE  = 3'd4
    } arb_state_e;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: loader first, then data, with instruction fetch
// promoted once data has won MAX_BURST times in a row while a fetch was waiting.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic                l_req_i,
    input  logic [STREAK_W-1:0] streak_i,
    input  logic [STREAK_W-1:0] max_burst_i,
    output logic [1:0]          owner_o
);

    always_comb begin
        owner_o = OWN_NONE;
        if (l_req_i) begin
            owner_o = OWN_L;
        end else if (d_req_i && !(i_req_i && (streak_i == max_burst_i))) begin
            owner_o = OWN_D;
        end else if (i_req_i) begin
            owner_o = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch, load/store and boot-loader requests onto one single-port RAM.
// Every output is a register; one access is in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_ack,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [STREAK_W-1:0] MAX_BURST_W = STREAK_W'(MAX_BURST);
    localparam logic [1:0]          WAIT_INIT   = 2'(MEM_LAT - 1);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                wen_q, wen_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [1:0]          pick_raw;
    owner_e              pick;

    logic                mem_en_q, mem_wen_q, busy_q;
    logic                i_ack_q, d_ack_q, l_ack_q;
    logic [31:0]         i_rdata_q, d_rdata_q;

    mem_arb_pick u_pick (
        .i_req_i     (i_req),
        .d_req_i     (d_req),
        .l_req_i     (l_req),
        .streak_i    (streak_q),
        .max_burst_i (MAX_BURST_W),
        .owner_o     (pick_raw)
    );

    assign pick = owner_e'(pick_raw);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;

        case (state_q)
            ARB_IDLE: begin
                owner_d = pick;
                if (!i_req || pick == OWN_I) begin
                    streak_d = '0;
                end else if (pick == OWN_D && streak_q != MAX_BURST_W) begin
                    streak_d = streak_q + 1'b1;
                end
                case (pick)
                    OWN_L: begin
                        wen_d   = 1'b1;
                        addr_d  = l_addr;
                        wdata_d = l_wdata;
                    end
                    OWN_D: begin
                        wen_d   = d_wen;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end
                    OWN_I: begin
                        wen_d   = 1'b0;
                        addr_d  = i_addr;
                    end
                    default: ;
                endcase
                if (pick != OWN_NONE) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (wen_q) begin
                    state_d = ARB_DONE;
                end else if (MEM_LAT == 1) begin
                    state_d = ARB_CAPT;
                end else begin
                    state_d = ARB_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 2'd1) state_d = ARB_CAPT;
            end
            ARB_CAPT: state_d = ARB_DONE;
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Outputs are registered from next-state so the strobe and acks line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_NONE;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            streak_q  <= '0;
            mem_en_q  <= 1'b0;
            mem_wen_q <= 1'b0;
            busy_q    <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            l_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
            state_q   <= state_d;
            owner_q   <= owner_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            mem_en_q  <= (state_d == ARB_ISSUE);
            mem_wen_q <= (state_d == ARB_ISSUE) && wen_d;
            busy_q    <= (state_d != ARB_IDLE);
            i_ack_q   <= (state_d == ARB_DONE) && (owner_q == OWN_I);
            d_ack_q   <= (state_d == ARB_DONE) && (owner_q == OWN_D);
            l_ack_q   <= (state_d == ARB_DONE) && (owner_q == OWN_L);
            if (state_q == ARB_CAPT && owner_q == OWN_I) i_rdata_q <= mem_rdata;
            if (state_q == ARB_CAPT && owner_q == OWN_D) d_rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign l_ack     = l_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
